// File: rtl/sram_1r1w_init_ext.sv
// Behavioural 1R1W SRAM macro model with a post-reset init sweep, a 1- or 2-cycle read
// pipeline and optional same-address write-to-read bypass.
module sram_1r1w_init_ext #(
  parameter int               DEPTH        = 32,
  parameter int               WIDTH        = 256,
  parameter int               MASK_SEGS    = 8,
  parameter int               READ_LATENCY = 1,
  parameter int               BYPASS       = 1,
  parameter logic [WIDTH-1:0] INIT_VALUE   = {WIDTH{1'b0}},
  localparam int              AW           = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 ready,
  input  logic                 R0_en,
  input  logic [AW-1:0]        R0_addr,
  output logic                 R0_valid,
  output logic [WIDTH-1:0]     R0_data,
  input  logic                 W0_en,
  input  logic [AW-1:0]        W0_addr,
  input  logic [MASK_SEGS-1:0] W0_mask,
  input  logic [WIDTH-1:0]     W0_data
);

  localparam int            SEG     = WIDTH / MASK_SEGS;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IX = AW'(DEPTH - 1);

  if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : g_bad_latency
    $error("sram_1r1w_init_ext: READ_LATENCY must be 1 or 2");
  end
  if ((WIDTH % MASK_SEGS) != 0) begin : g_bad_mask
    $error("sram_1r1w_init_ext: WIDTH must be a multiple of MASK_SEGS");
  end

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [WIDTH-1:0] merge_segs(input logic [WIDTH-1:0]     old_v,
                                                  input logic [WIDTH-1:0]     new_v,
                                                  input logic [MASK_SEGS-1:0] mask);
    logic [WIDTH-1:0] res;
    res = old_v;
    for (int i = 0; i < MASK_SEGS; i++) begin
      if (mask[i]) begin
        res[i*SEG +: SEG] = new_v[i*SEG +: SEG];
      end else begin
        res[i*SEG +: SEG] = old_v[i*SEG +: SEG];
      end
    end
    return res;
  endfunction

  logic [WIDTH-1:0] mem_q [DEPTH];
  state_e           state_q;
  logic [AW-1:0]    init_cnt_q;
  logic             ready_q;
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_data_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  logic             rd_req_s;
  logic             wr_req_s;
  logic             rd_inrange_s;
  logic [WIDTH-1:0] rd_data_d;

  assign rd_req_s     = ready_q & R0_en;
  assign wr_req_s     = ready_q & W0_en & ({1'b0, W0_addr} < DEPTH_W);
  assign rd_inrange_s = ({1'b0, R0_addr} < DEPTH_W);

  // Array read with optional forwarding of a same-cycle write to the same entry.
  always_comb begin
    rd_data_d = {WIDTH{1'b0}};
    if (rd_inrange_s) begin
      if ((BYPASS != 0) && wr_req_s && (W0_addr == R0_addr)) begin
        rd_data_d = merge_segs(mem_q[R0_addr], W0_data, W0_mask);
      end else begin
        rd_data_d = mem_q[R0_addr];
      end
    end else begin
      rd_data_d = {WIDTH{1'b0}};
    end
  end

  // Init sweep FSM: one entry per cycle, then RUN until the next reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      init_cnt_q <= {AW{1'b0}};
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (init_cnt_q == LAST_IX) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + {{(AW-1){1'b0}}, 1'b1};
          end
        end
        ST_RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_INIT;
          init_cnt_q <= {AW{1'b0}};
          ready_q    <= 1'b0;
        end
      endcase
    end
  end

  // Storage: the sweep owns the array until ready, then the write port does.
  always_ff @(posedge clock) begin
    if (state_q == ST_INIT) begin
      mem_q[init_cnt_q] <= INIT_VALUE;
    end else if (wr_req_s) begin
      mem_q[W0_addr] <= merge_segs(mem_q[W0_addr], W0_data, W0_mask);
    end
  end

  // Read pipeline; output data only moves when a result lands.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {WIDTH{1'b0}};
    end else if (READ_LATENCY == 1) begin
      out_valid_q <= rd_req_s;
      if (rd_req_s) begin
        out_data_q <= rd_data_d;
      end
    end else begin
      s1_valid_q  <= rd_req_s;
      if (rd_req_s) begin
        s1_data_q <= rd_data_d;
      end
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_data_q <= s1_data_q;
      end
    end
  end

  assign ready    = ready_q;
  assign R0_valid = out_valid_q;
  assign R0_data  = out_data_q;

endmodule
